// File: rtl/fmap_ram_stream.sv
// Feature-map RAM: byte-masked host port, hardware clear sweep, and a burst-read
// engine streaming a wrapping address range over valid/ready with at most 2 words buffered.
module fmap_ram_stream_lane (
    input  logic       be,
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] merged
);
    assign merged = be ? new_byte : old_byte;
endmodule

module fmap_ram_stream #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 1024,
    parameter int AW         = $clog2(DEPTH),
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic               rd,
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wbe,
    output logic [WIDTH-1:0]   rdata,
    output logic               rdata_valid,
    output logic               wr_ack,
    output logic               busy,
    input  logic               clear_start,
    input  logic               burst_start,
    input  logic [AW-1:0]      burst_addr,
    input  logic [AW:0]        burst_len,
    output logic [WIDTH-1:0]   bs_data,
    output logic               bs_valid,
    input  logic               bs_ready,
    output logic               bs_last
);
    localparam int NB = WIDTH / 8;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [1:0]       state;
    logic             init_pend;
    logic [AW-1:0]    clr_addr, rd_ptr;
    logic [AW:0]      issue_left, xfer_left;
    logic [WIDTH-1:0] mem_q, rd_word, wmerge;
    logic             mem_v;
    logic             idle, host_wr, host_rd, len_ok, start_clr, start_bst;
    logic             pop, move, issue;

    assign rd_word = mem[addr];

    for (genvar i = 0; i < NB; i++) begin : g_lane
        fmap_ram_stream_lane u_lane (
            .be       (wbe[i]),
            .old_byte (rd_word[8*i +: 8]),
            .new_byte (wdata[8*i +: 8]),
            .merged   (wmerge[8*i +: 8])
        );
    end

    assign idle      = (state == S_IDLE);
    assign busy      = ~idle;
    assign host_wr   = idle & wr & ~rst;
    assign host_rd   = idle & rd;
    assign len_ok    = (burst_len != '0) && (burst_len <= (AW+1)'(DEPTH));
    assign start_clr = idle & (clear_start | init_pend);
    assign start_bst = idle & ~start_clr & burst_start & len_ok;

    // Two-slot stream pipe: mem_q (read register) feeds the bs_* output register.
    // A read is issued only when mem_q is empty or draining this edge.
    assign pop     = bs_valid & bs_ready;
    assign move    = mem_v & (~bs_valid | pop);
    assign issue   = (state == S_BURST) & (issue_left != '0) & (~mem_v | move);
    assign bs_last = bs_valid & (xfer_left == (AW+1)'(1));

    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            mem[clr_addr] <= '0;
        else if (host_wr)
            mem[addr] <= wmerge;
        if (issue)
            mem_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            init_pend   <= INIT_CLEAR;
            clr_addr    <= '0;
            rd_ptr      <= '0;
            issue_left  <= '0;
            xfer_left   <= '0;
            mem_v       <= 1'b0;
            bs_valid    <= 1'b0;
            bs_data     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            wr_ack      <= 1'b0;
        end else begin
            wr_ack      <= host_wr;
            rdata_valid <= host_rd;
            if (host_rd)
                rdata <= host_wr ? wmerge : rd_word;  // write-first on same-cycle wr&rd

            case (state)
                S_IDLE: begin
                    if (start_clr) begin
                        state     <= S_CLEAR;
                        clr_addr  <= '0;
                        init_pend <= 1'b0;
                    end else if (start_bst) begin
                        state      <= S_BURST;
                        rd_ptr     <= burst_addr;
                        issue_left <= burst_len;
                        xfer_left  <= burst_len;
                    end
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (&clr_addr)
                        state <= S_IDLE;
                end
                S_BURST: begin
                    if (pop && xfer_left == (AW+1)'(1))
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (issue) begin
                rd_ptr     <= rd_ptr + 1'b1;
                issue_left <= issue_left - 1'b1;
            end
            if (issue)
                mem_v <= 1'b1;
            else if (move)
                mem_v <= 1'b0;
            if (move) begin
                bs_valid <= 1'b1;
                bs_data  <= mem_q;
            end else if (pop) begin
                bs_valid <= 1'b0;
            end
            if (pop)
                xfer_left <= xfer_left - 1'b1;
        end
    end
endmodule

// File: tb/tb_fmap_ram_stream.sv
// Directed bench for fmap_ram_stream: clear sweep, byte-masked host port,
// bursts checked against a queue of expected words.
module tb_fmap_ram_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr, rd;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  wbe;
    logic [63:0] rdata;
    logic        rdata_valid, wr_ack, busy;
    logic        clear_start, burst_start;
    logic [9:0]  burst_addr;
    logic [10:0] burst_len;
    logic [63:0] bs_data;
    logic        bs_valid, bs_ready, bs_last;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] q[$];

    fmap_ram_stream #(.WIDTH(64), .DEPTH(1024), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .wbe(wbe),
        .rdata(rdata), .rdata_valid(rdata_valid), .wr_ack(wr_ack), .busy(busy),
        .clear_start(clear_start), .burst_start(burst_start), .burst_addr(burst_addr),
        .burst_len(burst_len), .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
        .bs_last(bs_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 64'(n), 64'd1024);
    endtask

    task automatic host_write(input logic [9:0] a, input logic [63:0] d, input logic [7:0] be);
        wr = 1'b1; addr = a; wdata = d; wbe = be;
        @(negedge clk);
        wr = 1'b0;
        chk("wr_ack_pulse", wr_ack, 1'b1);
        @(negedge clk);
        chk("wr_ack_drop", wr_ack, 1'b0);
    endtask

    task automatic host_read(input string tag, input logic [9:0] a, input logic [63:0] exp);
        rd = 1'b1; addr = a;
        @(negedge clk);
        rd = 1'b0;
        chk({tag, "_valid"}, rdata_valid, 1'b1);
        chk(tag, rdata, exp);
        @(negedge clk);
        chk({tag, "_vdrop"}, rdata_valid, 1'b0);
        chk({tag, "_hold"}, rdata, exp);
    endtask

    task automatic run_burst(input logic [9:0] a, input logic [10:0] n, input bit rnd, input bit inj);
        bit stall = 1'b0;
        logic [63:0] prev_d = '0;
        logic prev_l = 1'b0;
        int cyc = 0;
        q.delete();
        for (int k = 0; k < int'(n); k++) q.push_back(64'((int'(a) + k) % 1024));
        burst_addr = a; burst_len = n; burst_start = 1'b1; bs_ready = 1'b0;
        @(negedge clk);
        burst_start = 1'b0;
        chk("bst_busy", busy, 1'b1);
        chk("bst_lat0", bs_valid, 1'b0);
        if (inj) begin
            wr = 1'b1; rd = 1'b1; addr = 10'd20; wdata = '1; wbe = '1;
        end
        @(negedge clk);
        if (inj) begin
            wr = 1'b0; rd = 1'b0;
            chk("busy_wr_ack", wr_ack, 1'b0);
            chk("busy_rd_valid", rdata_valid, 1'b0);
        end
        chk("bst_lat1", bs_valid, 1'b0);
        @(negedge clk);
        chk("bst_first", bs_valid, 1'b1);
        while (q.size() != 0 && cyc < 200) begin
            if (stall) begin
                chk("hold_valid", bs_valid, 1'b1);
                chk("hold_data", bs_data, prev_d);
                chk("hold_last", bs_last, prev_l);
            end
            if (!rnd) chk("no_bubble", bs_valid, 1'b1);
            bs_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bs_valid && bs_ready) begin
                logic [63:0] e;
                e = q.pop_front();
                chk("bst_data", bs_data, e);
                chk("bst_last", bs_last, q.size() == 0);
            end
            stall = bs_valid && !bs_ready;
            prev_d = bs_data; prev_l = bs_last;
            @(negedge clk);
            cyc++;
        end
        if (q.size() != 0) chk("bst_timeout", 64'(q.size()), 64'd0);
        chk("bst_busy_fall", busy, 1'b0);
        chk("bst_valid_fall", bs_valid, 1'b0);
        bs_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; wr = 0; rd = 0; addr = 0; wdata = 0; wbe = 0;
        clear_start = 0; burst_start = 0; burst_addr = 0; burst_len = 0; bs_ready = 0;
        #12;
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rvalid", rdata_valid, 1'b0);
        chk("rst_wr_ack", wr_ack, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bs_valid", bs_valid, 1'b0);
        chk("rst_bs_last", bs_last, 1'b0);
        chk("rst_bs_data", bs_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_clear("init_clear_len");

        // nonzero data, then clear_start alongside burst_start: clear must win
        host_write(10'd0, 64'h1, 8'hFF);
        host_write(10'd511, 64'h2, 8'hFF);
        host_write(10'd1023, 64'h3, 8'hFF);
        clear_start = 1'b1; burst_start = 1'b1; burst_addr = 0; burst_len = 11'd4;
        @(negedge clk);
        clear_start = 1'b0; burst_start = 1'b0;
        wait_clear("clear_len");
        chk("clear_no_stream", bs_valid, 1'b0);
        host_read("clr_rd0", 10'd0, 64'd0);
        host_read("clr_rd511", 10'd511, 64'd0);
        host_read("clr_rd1023", 10'd1023, 64'd0);

        host_write(10'd5, 64'h1122334455667788, 8'hFF);
        host_write(10'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        host_read("be_merge", 10'd5, 64'h11223344AAAAAAAA);

        wr = 1'b1; rd = 1'b1; addr = 10'd9; wdata = 64'hDEAD; wbe = 8'hFF;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        chk("wf_valid", rdata_valid, 1'b1);
        chk("wf_ack", wr_ack, 1'b1);
        chk("wf_data", rdata, 64'hDEAD);
        @(negedge clk);

        for (int i = 0; i < 1024; i++) begin
            wr = 1'b1; addr = 10'(i); wdata = 64'(i); wbe = 8'hFF;
            @(negedge clk);
        end
        wr = 1'b0;
        @(negedge clk);

        run_burst(10'd1020, 11'd8, 1'b0, 1'b0);
        run_burst(10'd0, 11'd16, 1'b1, 1'b0);
        run_burst(10'd18, 11'd4, 1'b0, 1'b1);
        host_read("busy_wr_ignored", 10'd20, 64'd20);

        burst_start = 1'b1; burst_addr = 0; burst_len = 11'd0;
        @(negedge clk);
        chk("len0_busy", busy, 1'b0);
        burst_len = 11'd1025;
        @(negedge clk);
        burst_start = 1'b0;
        chk("len_over_busy", busy, 1'b0);
        @(negedge clk);

        // reset after exactly 3 transfers
        burst_start = 1'b1; burst_addr = 0; burst_len = 11'd16; bs_ready = 1'b1;
        @(negedge clk);
        burst_start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", bs_valid, 1'b0);
        chk("mid_rst_data", bs_data, 64'd0);
        chk("mid_rst_last", bs_last, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bs_valid) cnt++;
        end
        chk("post_rst_no_valid", 64'(cnt), 64'd0);
        bs_ready = 1'b0;
        cnt = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        chk("post_rst_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
